// File: rtl/bufgce_ctrl_pkg.sv
// Shared types and helpers for the BUFGCE clock-enable scheduler.
// The state encoding is visible on the debug port, so the values are fixed.
package bufgce_ctrl_pkg;

  localparam int STATE_W     = 2;
  localparam int NUM_REQ_MAX = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Wide enough to hold the largest value any timeout can load.
  function automatic int tmr_width(input int wake_cycles,
                                   input int idle_cycles,
                                   input int min_off);
    int max_v;
    max_v = wake_cycles;
    if (idle_cycles > max_v) max_v = idle_cycles;
    if (min_off > max_v) max_v = min_off;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/bufgce_ctrl_timer.sv
// Loadable down-counter shared by every timeout of the scheduler.
// Load has priority over decrement; decrement saturates at zero.
module bufgce_ctrl_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bufgce_ctrl.sv
// Drives the CE pin of a BUFGCE on behalf of NUM_REQ level requesters:
// wake settle before ACK, idle timeout before CE drops, enforced minimum off time.
module bufgce_ctrl
  import bufgce_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int MIN_OFF     = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               force_on_i,
  output logic               ce_out_o,
  output logic [NUM_REQ-1:0] ack_o,
  output logic [STATE_W-1:0] state_o
);

  localparam int TW = tmr_width(WAKE_CYCLES, IDLE_CYCLES, MIN_OFF);
  localparam logic [TW-1:0] WAKE_LD = TW'(WAKE_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_LD = TW'(IDLE_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LD  = TW'(MIN_OFF - 1);

  if (NUM_REQ < 1 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
    $error("bufgce_ctrl: NUM_REQ must be 1..16");
  end
  if (WAKE_CYCLES < 1) begin : g_bad_wake
    $error("bufgce_ctrl: WAKE_CYCLES must be >= 1");
  end
  if (IDLE_CYCLES < 1) begin : g_bad_idle
    $error("bufgce_ctrl: IDLE_CYCLES must be >= 1");
  end
  if (MIN_OFF < 1) begin : g_bad_min_off
    $error("bufgce_ctrl: MIN_OFF must be >= 1");
  end

  state_e               state_q;
  logic                 ce_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 any_req;
  logic                 tmr_load;
  logic                 tmr_dec;
  logic                 tmr_zero;
  logic [TW-1:0]        tmr_val;

  assign any_req = (|req_i) | force_on_i;

  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_OFF: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (any_req) begin
          tmr_load = 1'b1;
          tmr_val  = WAKE_LD;
        end
      end
      ST_WAKE: tmr_dec = !tmr_zero;
      ST_ON: begin
        if (!any_req) begin
          tmr_load = 1'b1;
          tmr_val  = IDLE_LD;
        end
      end
      ST_HOLD: begin
        // A returning request resumes ON without touching the counter.
        if (!any_req) begin
          if (!tmr_zero) begin
            tmr_dec = 1'b1;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = OFF_LD;
          end
        end
      end
      default: ;
    endcase
  end

  bufgce_ctrl_timer #(
    .W (TW)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_OFF;
      ce_q    <= 1'b0;
      ack_q   <= '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (tmr_zero && any_req) begin
            state_q <= ST_WAKE;
            ce_q    <= 1'b1;
          end
        end
        ST_WAKE: begin
          // Never aborts: once CE rose it must reach ON to honour pulse width.
          if (tmr_zero) begin
            state_q <= ST_ON;
            ack_q   <= req_i;
          end
        end
        ST_ON: begin
          if (any_req) begin
            ack_q <= req_i;
          end else begin
            state_q <= ST_HOLD;
            ack_q   <= '0;
          end
        end
        ST_HOLD: begin
          if (any_req) begin
            state_q <= ST_ON;
          end else if (tmr_zero) begin
            state_q <= ST_OFF;
            ce_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_OFF;
          ce_q    <= 1'b0;
          ack_q   <= '0;
        end
      endcase
    end
  end

  assign ce_out_o = ce_q;
  assign ack_o    = ack_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_bufgce_ctrl.sv
// Bench for bufgce_ctrl: elapsed-time reference model checked every cycle,
// a directed timeline with literal expectations, then randomized requests.
module tb_bufgce_ctrl;

  localparam int N     = 4;
  localparam int WAKE  = 2;
  localparam int IDLE  = 16;
  localparam int MINOF = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         force_on;
  logic         ce;
  logic [N-1:0] ack;
  logic [1:0]   state;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  bufgce_ctrl #(
    .NUM_REQ     (N),
    .WAKE_CYCLES (WAKE),
    .IDLE_CYCLES (IDLE),
    .MIN_OFF     (MINOF)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_i      (req),
    .force_on_i (force_on),
    .ce_out_o   (ce),
    .ack_o      (ack),
    .state_o    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counts elapsed edges since CE rose, since CE fell and
  // since the last idle edge, and derives the outputs from those spans.
  bit           m_ce;
  bit           m_acking;
  bit           m_hold;
  logic [N-1:0] m_ack;
  int           m_off_cnt;
  int           m_since_rise;
  int           m_idle;
  bit           m_any;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ce = 0; m_acking = 0; m_hold = 0; m_ack = '0;
      m_off_cnt = MINOF; m_since_rise = 0; m_idle = 0;
    end else begin
      m_any = (|req) || force_on;
      if (!m_ce) begin
        if (m_off_cnt < MINOF) m_off_cnt++;
        if (m_off_cnt >= MINOF && m_any) begin
          m_ce = 1; m_since_rise = 0;
        end
      end else if (!m_acking) begin
        m_since_rise++;
        if (m_since_rise >= WAKE) begin
          m_acking = 1; m_ack = req;
        end
      end else if (!m_hold) begin
        if (m_any) m_ack = req;
        else begin
          m_ack = '0; m_hold = 1; m_idle = 0;
        end
      end else begin
        if (m_any) m_hold = 0;
        else begin
          m_idle++;
          if (m_idle >= IDLE) begin
            m_ce = 0; m_acking = 0; m_hold = 0; m_off_cnt = 0;
          end
        end
      end
    end
  end

  function automatic logic [1:0] exp_state();
    if (!m_ce) return 2'd0;
    if (!m_acking) return 2'd1;
    if (!m_hold) return 2'd2;
    return 2'd3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d t=%0t: got %0h expected %0h", name, edge_n, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("model_ce", 32'(ce), 32'(m_ce));
    check("model_ack", 32'(ack), 32'(m_ack));
    check("model_state", 32'(state), 32'(exp_state()));
  end

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = '0; force_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ce", 32'(ce), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    rst_n = 1'b1;
    edge_n = 0;

    // Wake-up from reset
    run_to(2); req = 4'b0001;
    run_to(3);
    check("wake_ce", 32'(ce), 32'd1);
    check("wake_state", 32'(state), 32'd1);
    run_to(4); check("wake_ack_early", 32'(ack), 32'd0);
    run_to(5);
    check("wake_ack", 32'(ack), 32'h1);
    check("on_state", 32'(state), 32'd2);

    // ACK tracks REQ with one-cycle latency in ON
    run_to(9); req = 4'b0011;
    run_to(10); check("on_ack_rise", 32'(ack), 32'h3);
    run_to(11); req = 4'b0010;
    run_to(12);
    check("on_ack_fall", 32'(ack), 32'h2);
    check("on_ce", 32'(ce), 32'd1);

    // Idle timeout, then minimum off time holds off a new request
    run_to(19); req = 4'b0000;
    run_to(20);
    check("idle_ack", 32'(ack), 32'd0);
    check("hold_state", 32'(state), 32'd3);
    run_to(35); check("hold_ce_late", 32'(ce), 32'd1);
    run_to(36);
    check("off_ce", 32'(ce), 32'd0);
    check("off_state", 32'(state), 32'd0);
    req = 4'b0001;
    run_to(37); check("minoff_ce", 32'(ce), 32'd0);
    run_to(38); check("rewake_ce", 32'(ce), 32'd1);
    run_to(39); check("rewake_ack_early", 32'(ack), 32'd0);
    run_to(40); check("rewake_ack", 32'(ack), 32'h1);

    // Reassert during HOLD: back to ON without a wake
    run_to(44); req = 4'b0000;
    run_to(45); check("hold2_state", 32'(state), 32'd3);
    run_to(49); req = 4'b0100;
    run_to(50);
    check("reassert_state", 32'(state), 32'd2);
    check("reassert_ack0", 32'(ack), 32'd0);
    check("reassert_ce", 32'(ce), 32'd1);
    run_to(51); check("reassert_ack", 32'(ack), 32'h4);

    // Reassert exactly when the idle timer expires: ANY wins
    run_to(54); req = 4'b0000;
    run_to(55); check("hold3_state", 32'(state), 32'd3);
    run_to(70); req = 4'b0100;
    run_to(71);
    check("tie_state", 32'(state), 32'd2);
    check("tie_ce", 32'(ce), 32'd1);
    run_to(72); check("tie_ack", 32'(ack), 32'h4);

    // FORCE_ON keeps the clock on but never acknowledges
    run_to(79); req = 4'b0000;
    run_to(96); check("f_off_ce", 32'(ce), 32'd0);
    force_on = 1'b1;
    run_to(97); check("f_minoff_ce", 32'(ce), 32'd0);
    run_to(98); check("f_wake_ce", 32'(ce), 32'd1);
    run_to(100); check("f_on_state", 32'(state), 32'd2);
    run_to(140);
    check("f_long_ce", 32'(ce), 32'd1);
    check("f_long_ack", 32'(ack), 32'd0);
    force_on = 1'b0;

    // Asynchronous reset mid-WAKE and mid-ON
    run_to(157); check("pre_rst_off", 32'(ce), 32'd0);
    run_to(160); req = 4'b0001;
    run_to(161); check("rst_wake_state", 32'(state), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_wake_ce", 32'(ce), 32'd0);
    check("async_wake_state", 32'(state), 32'd0);
    run_to(163);
    rst_n = 1'b1;
    run_to(164); check("rel_ce", 32'(ce), 32'd1);
    run_to(165); check("rel_ack_early", 32'(ack), 32'd0);
    run_to(166); check("rel_ack", 32'(ack), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_on_ce", 32'(ce), 32'd0);
    check("async_on_ack", 32'(ack), 32'd0);
    run_to(168);
    rst_n = 1'b1;
    run_to(169); check("rel2_ce", 32'(ce), 32'd1);
    run_to(170); check("rel2_ack_early", 32'(ack), 32'd0);
    run_to(171); check("rel2_ack", 32'(ack), 32'h1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0)
        req = ($urandom_range(1) == 0) ? 4'b0000 : 4'($urandom);
      if ($urandom_range(63) == 0) force_on = ~force_on;
      if ($urandom_range(199) == 0) begin
        req = '0; force_on = 1'b0;
        repeat ($urandom_range(25, 10)) tick();
      end
      if ($urandom_range(1499) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick();
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
